// File: rtl/obi_rr_arbiter.sv
// Round-robin arbiter sharing one OBI subordinate between NumPorts managers.
// Responses are steered back in order through a port-index FIFO.
module obi_rr_arbiter #(
  parameter int unsigned NumPorts  = 2,
  parameter int unsigned MaxTrans  = 2,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NumPorts-1:0]             sbr_req_i,
  output logic [NumPorts-1:0]             sbr_gnt_o,
  input  logic [NumPorts*AddrWidth-1:0]   sbr_addr_i,
  input  logic [NumPorts-1:0]             sbr_we_i,
  input  logic [NumPorts*DataWidth/8-1:0] sbr_be_i,
  input  logic [NumPorts*DataWidth-1:0]   sbr_wdata_i,
  output logic [NumPorts-1:0]             sbr_rvalid_o,
  output logic [NumPorts*DataWidth-1:0]   sbr_rdata_o,
  output logic [NumPorts-1:0]             sbr_err_o,
  output logic                            mgr_req_o,
  input  logic                            mgr_gnt_i,
  output logic [AddrWidth-1:0]            mgr_addr_o,
  output logic                            mgr_we_o,
  output logic [DataWidth/8-1:0]          mgr_be_o,
  output logic [DataWidth-1:0]            mgr_wdata_o,
  input  logic                            mgr_rvalid_i,
  input  logic [DataWidth-1:0]            mgr_rdata_i,
  input  logic                            mgr_err_i,
  output logic                            busy_o,
  output logic                            protocol_err_o
);

  localparam int unsigned IdxW = (NumPorts > 1) ? $clog2(NumPorts) : 1;
  localparam int unsigned PtrW = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
  localparam int unsigned CntW = $clog2(MaxTrans + 1);
  localparam int unsigned BeW  = DataWidth / 8;

  typedef enum logic [0:0] {StIdle, StLocked} lock_state_e;

  lock_state_e     r_state;
  logic [IdxW-1:0] r_lock_idx;
  logic [IdxW-1:0] r_rr_ptr;
  logic [CntW-1:0] r_cnt;
  logic [PtrW-1:0] r_wptr;
  logic [PtrW-1:0] r_rptr;
  logic [IdxW-1:0] r_fifo [MaxTrans];
  logic            r_proto_err;

  logic            w_can_issue;
  logic            w_rr_found;
  logic [IdxW-1:0] w_rr_sel;
  logic [IdxW-1:0] w_sel;
  logic            w_req;
  logic            w_push;
  logic            w_pop;
  logic            w_spurious;
  logic [IdxW-1:0] w_head;

  function automatic logic [IdxW-1:0] wrap_add(logic [IdxW-1:0] base, int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NumPorts) s -= NumPorts;
    return IdxW'(s);
  endfunction

  function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
    return (p == PtrW'(MaxTrans - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // A full window blocks issue even when a response frees a slot this cycle.
  assign w_can_issue = !rst_i && (r_cnt < CntW'(MaxTrans));

  always_comb begin
    w_rr_found = 1'b0;
    w_rr_sel   = '0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      if (!w_rr_found && sbr_req_i[wrap_add(r_rr_ptr, i)]) begin
        w_rr_found = 1'b1;
        w_rr_sel   = wrap_add(r_rr_ptr, i);
      end
    end
  end

  // While locked the stalled port keeps the bus so its request stays stable.
  always_comb begin
    if (r_state == StLocked) begin
      w_sel = r_lock_idx;
      w_req = sbr_req_i[r_lock_idx] && w_can_issue;
    end else begin
      w_sel = w_rr_sel;
      w_req = w_rr_found && w_can_issue;
    end
  end

  assign w_push     = w_req && mgr_gnt_i;
  assign w_pop      = !rst_i && mgr_rvalid_i && (r_cnt != '0);
  assign w_spurious = mgr_rvalid_i && (r_cnt == '0);
  assign w_head     = r_fifo[r_rptr];

  always_comb begin
    mgr_addr_o  = '0;
    mgr_we_o    = 1'b0;
    mgr_be_o    = '0;
    mgr_wdata_o = '0;
    for (int unsigned k = 0; k < NumPorts; k++) begin
      if (w_sel == IdxW'(k)) begin
        mgr_addr_o  = sbr_addr_i[k*AddrWidth +: AddrWidth];
        mgr_we_o    = sbr_we_i[k];
        mgr_be_o    = sbr_be_i[k*BeW +: BeW];
        mgr_wdata_o = sbr_wdata_i[k*DataWidth +: DataWidth];
      end
    end
  end

  always_comb begin
    sbr_gnt_o    = '0;
    sbr_rvalid_o = '0;
    sbr_err_o    = '0;
    if (w_req) sbr_gnt_o[w_sel] = mgr_gnt_i;
    if (w_pop) begin
      sbr_rvalid_o[w_head] = 1'b1;
      sbr_err_o[w_head]    = mgr_err_i;
    end
  end

  assign mgr_req_o      = w_req;
  assign sbr_rdata_o    = {NumPorts{mgr_rdata_i}};
  assign busy_o         = !rst_i && (r_cnt != '0);
  assign protocol_err_o = !rst_i && r_proto_err;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= StIdle;
      r_lock_idx  <= '0;
      r_rr_ptr    <= '0;
      r_cnt       <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_push) begin
        r_fifo[r_wptr] <= w_sel;
        r_wptr         <= ptr_inc(r_wptr);
        r_rr_ptr       <= wrap_add(w_sel, 1);
      end
      if (w_pop) r_rptr <= ptr_inc(r_rptr);
      if (w_push && !w_pop) begin
        r_cnt <= r_cnt + CntW'(1);
      end else if (!w_push && w_pop) begin
        r_cnt <= r_cnt - CntW'(1);
      end
      if (w_spurious) r_proto_err <= 1'b1;
      unique case (r_state)
        StIdle: begin
          if (w_req && !mgr_gnt_i) begin
            r_state    <= StLocked;
            r_lock_idx <= w_sel;
          end
        end
        StLocked: begin
          if (mgr_gnt_i || !w_req) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_obi_rr_arbiter.sv
// Directed scenarios plus random traffic checked against a queue-based reference model.
module tb_obi_rr_arbiter;
  localparam int NP = 2;
  localparam int MT = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic [NP-1:0]     sbr_req_i = '0;
  logic [NP-1:0]     sbr_gnt_o;
  logic [NP*AW-1:0]  sbr_addr_i = '0;
  logic [NP-1:0]     sbr_we_i = '0;
  logic [NP*BW-1:0]  sbr_be_i = '0;
  logic [NP*DW-1:0]  sbr_wdata_i = '0;
  logic [NP-1:0]     sbr_rvalid_o;
  logic [NP*DW-1:0]  sbr_rdata_o;
  logic [NP-1:0]     sbr_err_o;
  logic              mgr_req_o;
  logic              mgr_gnt_i = 1'b0;
  logic [AW-1:0]     mgr_addr_o;
  logic              mgr_we_o;
  logic [BW-1:0]     mgr_be_o;
  logic [DW-1:0]     mgr_wdata_o;
  logic              mgr_rvalid_i = 1'b0;
  logic [DW-1:0]     mgr_rdata_i = '0;
  logic              mgr_err_i = 1'b0;
  logic              busy_o;
  logic              protocol_err_o;

  always #5 clk = ~clk;

  obi_rr_arbiter #(
    .NumPorts (NP),
    .MaxTrans (MT),
    .AddrWidth(AW),
    .DataWidth(DW)
  ) u_dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .sbr_req_i     (sbr_req_i),
    .sbr_gnt_o     (sbr_gnt_o),
    .sbr_addr_i    (sbr_addr_i),
    .sbr_we_i      (sbr_we_i),
    .sbr_be_i      (sbr_be_i),
    .sbr_wdata_i   (sbr_wdata_i),
    .sbr_rvalid_o  (sbr_rvalid_o),
    .sbr_rdata_o   (sbr_rdata_o),
    .sbr_err_o     (sbr_err_o),
    .mgr_req_o     (mgr_req_o),
    .mgr_gnt_i     (mgr_gnt_i),
    .mgr_addr_o    (mgr_addr_o),
    .mgr_we_o      (mgr_we_o),
    .mgr_be_o      (mgr_be_o),
    .mgr_wdata_o   (mgr_wdata_o),
    .mgr_rvalid_i  (mgr_rvalid_i),
    .mgr_rdata_i   (mgr_rdata_i),
    .mgr_err_i     (mgr_err_i),
    .busy_o        (busy_o),
    .protocol_err_o(protocol_err_o)
  );

  int checks = 0;
  int failures = 0;

  // Per-port request payloads
  logic [AW-1:0] p_addr  [NP];
  logic          p_we    [NP];
  logic [BW-1:0] p_be    [NP];
  logic [DW-1:0] p_wdata [NP];

  // Reference model: in-flight ports in grant order, next-priority port, stall lock
  int q[$];
  int rr = 0;
  bit locked = 0;
  int lport = 0;
  bit perr = 0;

  // DUT outputs captured at the last sample point
  logic [NP-1:0] s_gnt, s_rvalid, s_err;
  logic          s_mreq, s_busy, s_perr;
  logic [AW-1:0] s_addr;
  logic [NP*DW-1:0] s_rdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic [NP-1:0] req, input logic gnt, input logic rv,
                       input logic er, input logic rs, input logic [DW-1:0] rd);
    int sel;
    bit mreq, pop, spur;
    logic [NP-1:0] e_gnt, e_rv, e_err;
    @(negedge clk);
    rst_i = rs;
    sbr_req_i = req;
    mgr_gnt_i = gnt;
    mgr_rvalid_i = rv;
    mgr_err_i = er;
    mgr_rdata_i = rd;
    for (int k = 0; k < NP; k++) begin
      sbr_addr_i[k*AW +: AW]  = p_addr[k];
      sbr_we_i[k]             = p_we[k];
      sbr_be_i[k*BW +: BW]    = p_be[k];
      sbr_wdata_i[k*DW +: DW] = p_wdata[k];
    end
    #1;
    sel = -1; mreq = 0; pop = 0; spur = 0;
    e_gnt = '0; e_rv = '0; e_err = '0;
    if (!rs) begin
      if (locked) begin
        sel = lport;
        mreq = req[lport];
      end else begin
        for (int i = 0; i < NP; i++) begin
          int p;
          p = (rr + i) % NP;
          if (sel < 0 && req[p]) sel = p;
        end
        mreq = (sel >= 0);
      end
      if (q.size() >= MT) mreq = 0;
      if (mreq && gnt) e_gnt = NP'(1) << sel;
      pop = rv && (q.size() > 0);
      spur = rv && (q.size() == 0);
      if (pop) begin
        e_rv = NP'(1) << q[0];
        e_err = er ? e_rv : '0;
      end
    end
    s_gnt = sbr_gnt_o; s_rvalid = sbr_rvalid_o; s_err = sbr_err_o; s_mreq = mgr_req_o;
    s_busy = busy_o; s_perr = protocol_err_o; s_addr = mgr_addr_o; s_rdata = sbr_rdata_o;
    chk("sbr_gnt", sbr_gnt_o, e_gnt);
    chk("mgr_req", mgr_req_o, mreq);
    chk("sbr_rvalid", sbr_rvalid_o, e_rv);
    chk("sbr_err", sbr_err_o, e_err);
    chk("busy", busy_o, !rs && (q.size() != 0));
    chk("protocol_err", protocol_err_o, !rs && perr);
    chk("sbr_rdata", sbr_rdata_o, {NP{rd}});
    if (mreq) begin
      chk("mgr_addr", mgr_addr_o, p_addr[sel]);
      chk("mgr_we", mgr_we_o, p_we[sel]);
      chk("mgr_be", mgr_be_o, p_be[sel]);
      chk("mgr_wdata", mgr_wdata_o, p_wdata[sel]);
    end
    @(posedge clk);
    if (rs) begin
      q.delete();
      rr = 0; locked = 0; perr = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (spur) perr = 1;
      if (mreq && gnt) begin
        q.push_back(sel);
        rr = (sel + 1) % NP;
      end
      locked = mreq && !gnt;
      if (locked) lport = sel;
    end
  endtask

  initial begin
    for (int k = 0; k < NP; k++) begin
      p_addr[k] = 32'h100 * (k + 1); p_we[k] = 1'(k); p_be[k] = 4'hF; p_wdata[k] = $urandom;
    end

    // Reset, including requests and responses held during reset
    cycle(2'b00, 0, 0, 0, 1, 0);
    cycle(2'b11, 1, 1, 1, 1, 32'h1234);
    chk("rst_mreq", s_mreq, 1'b0);
    chk("rst_gnt", s_gnt, 2'b00);

    // Single port read
    cycle(2'b00, 0, 0, 0, 1, 0);
    p_addr[1] = 32'h0001_0000; p_we[1] = 1'b0;
    cycle(2'b10, 1, 0, 0, 0, 0);
    chk("single_gnt", s_gnt, 2'b10);
    chk("single_addr", s_addr, 32'h0001_0000);
    chk("single_busy0", s_busy, 1'b0);
    cycle(2'b00, 0, 1, 0, 0, 32'hDEAD_BEEF);
    chk("single_rvalid", s_rvalid, 2'b10);
    chk("single_rdata", s_rdata[2*DW-1:DW], 32'hDEAD_BEEF);
    chk("single_busy1", s_busy, 1'b1);
    cycle(2'b00, 0, 0, 0, 0, 0);
    chk("single_busy2", s_busy, 1'b0);

    // Fairness under continuous contention
    cycle(2'b00, 0, 0, 0, 1, 0);
    cycle(2'b11, 1, 0, 0, 0, 0);
    chk("fair_0", s_gnt, 2'b01);
    for (int i = 1; i < 8; i++) begin
      cycle(2'b11, 1, 1, 0, 0, $urandom);
      chk("fair_n", s_gnt, (i % 2) ? 2'b10 : 2'b01);
    end
    cycle(2'b00, 0, 1, 0, 0, 0);

    // Lock holds port 0 through a 3-cycle stall
    p_addr[0] = 32'h0000_A000; p_addr[1] = 32'h0000_B000;
    cycle(2'b00, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(2'b11, 0, 0, 0, 0, 0);
      chk("lock_addr", s_addr, 32'h0000_A000);
      chk("lock_nogrant", s_gnt, 2'b00);
    end
    cycle(2'b11, 1, 0, 0, 0, 0);
    chk("lock_addr3", s_addr, 32'h0000_A000);
    chk("lock_gnt3", s_gnt, 2'b01);
    cycle(2'b11, 1, 0, 0, 0, 0);
    chk("lock_next", s_gnt, 2'b10);
    cycle(2'b00, 0, 1, 0, 0, 0);
    cycle(2'b00, 0, 1, 0, 0, 0);

    // Lock must override priority when a higher-priority port appears
    cycle(2'b00, 0, 0, 0, 1, 0);
    cycle(2'b10, 0, 0, 0, 0, 0);
    cycle(2'b11, 0, 0, 0, 0, 0);
    chk("lock_prio_addr", s_addr, 32'h0000_B000);
    cycle(2'b11, 1, 0, 0, 0, 0);
    chk("lock_prio_gnt", s_gnt, 2'b10);
    cycle(2'b00, 0, 1, 0, 0, 0);

    // Outstanding limit
    cycle(2'b00, 0, 0, 0, 1, 0);
    cycle(2'b11, 1, 0, 0, 0, 0);
    cycle(2'b11, 1, 0, 0, 0, 0);
    cycle(2'b11, 1, 0, 0, 0, 0);
    chk("limit_req", s_mreq, 1'b0);
    chk("limit_gnt", s_gnt, 2'b00);
    cycle(2'b11, 1, 1, 0, 0, 32'h5555_AAAA);
    chk("limit_req_pop", s_mreq, 1'b0);
    chk("limit_rvalid", s_rvalid, 2'b01);
    cycle(2'b11, 1, 0, 0, 0, 0);
    chk("limit_regrant", s_gnt, 2'b01);
    cycle(2'b00, 0, 1, 0, 0, 0);
    chk("limit_drain1", s_rvalid, 2'b10);
    cycle(2'b00, 0, 1, 0, 0, 0);
    chk("limit_drain2", s_rvalid, 2'b01);

    // Response ordering and error routing
    cycle(2'b00, 0, 0, 0, 1, 0);
    cycle(2'b01, 1, 0, 0, 0, 0);
    cycle(2'b10, 1, 0, 0, 0, 0);
    cycle(2'b00, 0, 1, 0, 0, 32'h1);
    chk("order_rv0", s_rvalid, 2'b01);
    chk("order_err0", s_err, 2'b00);
    cycle(2'b00, 0, 1, 1, 0, 32'h2);
    chk("order_rv1", s_rvalid, 2'b10);
    chk("order_err1", s_err, 2'b10);

    // Reset with a transaction outstanding, then a late response
    cycle(2'b01, 1, 0, 0, 0, 0);
    cycle(2'b00, 0, 0, 0, 1, 0);
    chk("spur_busy_rst", s_busy, 1'b0);
    cycle(2'b00, 0, 1, 0, 0, 32'h3);
    chk("spur_rvalid", s_rvalid, 2'b00);
    chk("spur_perr0", s_perr, 1'b0);
    cycle(2'b00, 0, 0, 0, 0, 0);
    chk("spur_perr1", s_perr, 1'b1);
    cycle(2'b01, 1, 0, 0, 0, 0);
    chk("spur_perr_sticky", s_perr, 1'b1);
    cycle(2'b00, 0, 1, 0, 0, 0);
    cycle(2'b00, 0, 0, 0, 1, 0);
    chk("spur_perr_rst", s_perr, 1'b0);
    cycle(2'b00, 0, 0, 0, 0, 0);
    chk("spur_perr_clr", s_perr, 1'b0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      for (int k = 0; k < NP; k++) begin
        p_addr[k] = $urandom; p_we[k] = 1'($urandom_range(0, 1));
        p_be[k] = 4'($urandom_range(0, 15)); p_wdata[k] = $urandom;
      end
      cycle(NP'($urandom_range(0, 3)), ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 9) < 4), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 63) == 0), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/obi_rr_arbiter.md
Name: obi_rr_arbiter

Overview:
- Shares one OBI memory subordinate (the SRAM) between NumPorts OBI managers, e.g. the core's instruction and data ports.
- Arbitrates requests round-robin and limits in-flight transactions to MaxTrans.
- Routes each in-order response back to the originating port through an internal port-index FIFO.
- Sits between the core's OBI ports and the SRAM, in place of a generic mux, in both the compliance bench and the SoC.

Parameters:
- NumPorts, 2, number of requester (subordinate-side) OBI ports; range 2..8.
- MaxTrans, 2, maximum outstanding granted-but-unanswered transactions; range 1..8.
- AddrWidth, 32, OBI address width.
- DataWidth, 32, OBI data width; byte-enable width is DataWidth/8.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- sbr_req_i  in  NumPorts  per-port request.
- sbr_gnt_o  out  NumPorts  per-port grant.
- sbr_addr_i  in  NumPorts*AddrWidth  per-port address; port k occupies slice k.
- sbr_we_i  in  NumPorts  per-port write enable.
- sbr_be_i  in  NumPorts*DataWidth/8  per-port byte enables.
- sbr_wdata_i  in  NumPorts*DataWidth  per-port write data.
- sbr_rvalid_o  out  NumPorts  per-port response valid.
- sbr_rdata_o  out  NumPorts*DataWidth  response data; broadcast to every slice.
- sbr_err_o  out  NumPorts  per-port response error.
- mgr_req_o  out  1  request to memory.
- mgr_gnt_i  in  1  grant from memory.
- mgr_addr_o / mgr_we_o / mgr_be_o / mgr_wdata_o  out  AddrWidth/1/DataWidth/8/DataWidth  selected request payload.
- mgr_rvalid_i  in  1  response valid.
- mgr_rdata_i  in  DataWidth  response data.
- mgr_err_i  in  1  response error.
- busy_o  out  1  outstanding count is non-zero.
- protocol_err_o  out  1  sticky flag: response arrived with no transaction outstanding.

Behaviour:
- Reset: rst_i is synchronous and active-high. It clears the outstanding count, FIFO pointers, lock state, protocol_err_o and the round-robin pointer (pointer=0, port 0 highest priority). During and after reset all outputs are 0: sbr_gnt_o, sbr_rvalid_o, sbr_err_o, mgr_req_o, busy_o, protocol_err_o.
- Blocking: if cnt==MaxTrans, mgr_req_o=0 and no sbr_gnt_o asserts, even if a response pops in the same cycle. The freed slot becomes usable the following cycle.
- Selection (cnt<MaxTrans):
  - Pick the first requesting port scanning pointer, pointer+1, ..., wrapping modulo NumPorts.
  - Drive mgr_req_o=1 and mux that port's addr/we/be/wdata combinationally.
  - sbr_gnt_o[sel] = mgr_gnt_i, same cycle (zero added latency). All other grants are 0.
- Lock state machine:
  - States IDLE and LOCKED.
  - IDLE -> LOCKED when mgr_req_o=1 and mgr_gnt_i=0; the selected index is registered.
  - In LOCKED, the registered index is forced as the selection regardless of priority, keeping the request stable per OBI.
  - LOCKED -> IDLE on mgr_gnt_i=1.
  - A locked port is assumed to hold its request; if it drops it anyway, mgr_req_o follows it and the lock releases.
- Handshake: mgr_req_o & mgr_gnt_i completes a transaction. It pushes sel into the route FIFO (depth MaxTrans), increments cnt, and sets pointer=(sel+1) mod NumPorts.
- Response:
  - mgr_rvalid_i with cnt>0 asserts sbr_rvalid_o[head] and sbr_err_o[head]=mgr_err_i in the same cycle, then pops the FIFO and decrements cnt.
  - sbr_rdata_o slices all carry mgr_rdata_i.
- Simultaneous push and pop in one cycle: cnt is unchanged and FIFO ordering is preserved. This also applies with cnt==MaxTrans only in the sense that the pop still happens; no push occurs, per the blocking rule.
- Spurious response: mgr_rvalid_i with cnt==0 produces no sbr_rvalid_o and sets protocol_err_o, which stays set until reset.
- Reset mid-operation: outstanding entries are discarded. Any late mgr_rvalid_i after reset is handled as a spurious response and sets protocol_err_o.
- FIFO wrap-around: read and write pointers are modulo MaxTrans. cnt is a $clog2(MaxTrans+1)-bit counter.
- busy_o = (cnt!=0), registered-state based.

Test Plan:
- Single port: port 1 reads 0x1_0000, memory grants immediately and returns rvalid next cycle with rdata=0xDEADBEEF -> sbr_gnt_o=2'b10 in cycle 0; sbr_rvalid_o=2'b10 with rdata 0xDEADBEEF in cycle 1; busy_o high for exactly 1 cycle.
- Fairness: both ports request continuously, memory always grants, MaxTrans=2 -> grant order after reset is 0,1,0,1,..., with no port granted twice in a row.
- Lock: port 0 requests, mgr_gnt_i held low 3 cycles while port 1 also requests -> mgr_addr_o stays at port 0's address for all 4 cycles; port 0 is granted on cycle 3 and port 1 on the next grant.
- Outstanding limit: MaxTrans=2, memory grants but withholds rvalid -> after 2 grants mgr_req_o=0. A single rvalid returns data to the first granted port; the next grant occurs 1 cycle later.
- Ordering: port 0 grant then port 1 grant, two rvalids with mgr_err_i=1 on the second -> sbr_rvalid_o sequence 2'b01 then 2'b10; sbr_err_o=2'b10 only on the second.
- Reset and spurious: assert rst_i with 1 outstanding, then pulse mgr_rvalid_i after reset -> no sbr_rvalid_o, protocol_err_o=1 from the next cycle, cleared only by the next rst_i.
